// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for a shared 16:1 bit mux: one-hot grant plus select,
// bounded tenure, and one idle cycle between grants so sel never moves under a live grant.
module rr_arbiter_16 #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  output logic [15:0] gnt,
  output logic [3:0]  sel,
  output logic        busy
);

  // Handshake: req[i] is a level held until the requester is done; gnt[i] is
  // the registered acknowledge. A requester owns the mux for every cycle its
  // gnt bit is high, and releases it by dropping req[i] (or by tenure expiry).
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYCLES - 1);

  state_t      state;
  logic [3:0]  ptr;
  logic [7:0]  cnt;

  logic [3:0]  win;
  logic        win_vld;
  logic [3:0]  idx;
  logic        release_now;

  // First requester at or after ptr, wrapping 15 -> 0.
  always_comb begin
    win     = 4'h0;
    win_vld = 1'b0;
    idx     = 4'h0;
    for (int i = 0; i < 16; i++) begin
      idx = ptr + 4'(i);
      if (!win_vld && req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign release_now = !req[sel] || (cnt == 8'h00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 16'h0000;
      sel   <= 4'h0;
      busy  <= 1'b0;
      ptr   <= 4'h0;
      cnt   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            gnt   <= 16'b1 << win;
            sel   <= win;
            busy  <= 1'b1;
            cnt   <= HOLD_M1;
            state <= GRANT;
          end
        end
        GRANT: begin
          // sel holds through release; it only moves on the next IDLE->GRANT edge.
          if (release_now) begin
            gnt   <= 16'h0000;
            busy  <= 1'b0;
            ptr   <= sel + 4'h1;
            state <= IDLE;
          end else begin
            cnt <= cnt - 8'h01;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rr_arbiter_16.md
# rr_arbiter_16

Round-robin arbiter that shares the 16-to-1 bit multiplexer datapath among 16 requesters. It drives the mux 4-bit select and a one-hot grant vector. It enforces a bounded grant tenure and inserts one idle cycle between grants so the select is never switched while a grant is live. It sits directly in front of the 16:1 mux tree: the grant owner's data bit appears at the mux output for the whole tenure.

## Interface
- HOLD_CYCLES, default 4: maximum consecutive cycles a single grant is held; legal range 1..256.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- req  input  16  request vector; req[i] high means requester i wants the mux; level-sensitive, held until done.
- gnt  output  16  one-hot grant, registered; all-zero when no grant is live.
- sel  output  4  mux select, registered; equals the index of the granted requester while gnt is nonzero.
- busy  output  1  registered; high exactly when gnt is nonzero.

## Operation
- State: two-state FSM (IDLE, GRANT), 4-bit priority pointer ptr, 8-bit tenure counter cnt.
- Reset: state=IDLE, gnt=16'h0000, sel=4'h0, busy=0, ptr=0, cnt=0. Reset overrides everything, including mid-grant; the grant drops on the edge where rst is sampled high.
- IDLE, req==0: stay in IDLE; outputs unchanged (gnt=0, busy=0, sel holds last value).
- IDLE, req!=0: winner w is the first i with req[i]=1, searching ptr, ptr+1, ... mod 16 (wraps 15->0). The next edge sets gnt=1<<w, sel=w, busy=1, cnt=HOLD_CYCLES-1, and state=GRANT.
- GRANT, release condition (req[sel]==0 or cnt==0): the next edge sets gnt=0, busy=0, ptr=(sel+1) mod 16, and state=IDLE; sel holds.
- GRANT, otherwise: cnt decrements; gnt, sel and busy hold.
- A release is always followed by exactly one IDLE cycle with gnt=0, even if other requests are pending. The just-served requester has lowest priority at the next arbitration.
- Requests from non-granted requesters never affect a live grant (no preemption).
- sel changes only on the IDLE->GRANT edge, never while busy=1.
- Fairness: with all 16 requesting continuously, every requester is served once per 16 grants.

## Timing
- Arbitration latency: req seen in IDLE at edge k gives gnt/sel valid after edge k (1 cycle).
- Tenure: with req[w] held, gnt is high for exactly HOLD_CYCLES cycles, then low for 1 cycle.
- Early release: req[w] low at edge k gives gnt low after edge k. Tenure is at least 1 cycle even if req drops in the first granted cycle.
- Grant period under continuous contention: HOLD_CYCLES+1 cycles per grant.
- HOLD_CYCLES=1: gnt pulses 1 cycle, then 1 idle cycle.
- Simultaneous events: when the release condition and rst are both true, rst wins. A req arriving in the same cycle as a release is considered at the following IDLE arbitration.
- All outputs are registered; there are no combinational paths from req to gnt, sel or busy.

## Test plan
- Reset: assert rst for 2 cycles with req=16'hFFFF -> gnt=0, sel=0, busy=0 throughout. First grant goes to requester 0 one cycle after rst deasserts.
- Single requester: HOLD_CYCLES=4, req=16'h0020 held -> gnt=16'h0020, sel=5 for 4 cycles, 1 cycle gnt=0, then the pattern repeats indefinitely.
- Full contention: req=16'hFFFF, HOLD_CYCLES=2 -> sel sequence 0,1,...,15,0 with each grant lasting 2 cycles and separated by 1 idle cycle; never two grants at once.
- Wrap-around: after a grant to 14 (ptr=15), req=16'h8001 -> grant 15 next, then 0, then 15.
- Early release: grant to 3 (HOLD_CYCLES=8), drop req[3] in the 2nd granted cycle -> gnt drops the next cycle and the following grant goes to the next pending index above 3.
- Reset mid-grant: rst pulsed during the 3rd cycle of a grant to 9 -> gnt=0, sel=0 after that edge. Arbitration restarts from ptr=0.
